// File: rtl/ifu_fetch_ctrl.sv
// Fetch-stage sequencer: single-outstanding instruction-memory port, fetched-word hold register, fetch PC.
// Optional build macro FETCH_PERF_EN adds hand-off and decode-stall performance counters.
module ifu_fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  ifu_arvalid,
    input  logic                  ifu_arready,
    output logic [DATA_WIDTH-1:0] ifu_araddr,
    input  logic                  ifu_rvalid,
    output logic                  ifu_rready,
    input  logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic [1:0]            ifu_rresp,
    output logic                  Ivalid,
    input  logic                  Dready,
    output logic [DATA_WIDTH-1:0] InstF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   inst_q, inst_d;
    logic                    err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // DROP absorbs the response of a request that was accepted before a redirect squashed it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (ifu_arready) begin
                    state_d = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = ifu_rvalid ? S_REQ : S_DROP;
                end else if (ifu_rvalid) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || Dready) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (ifu_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        ifu_arvalid = 1'b0;
        ifu_rready  = 1'b0;
        Ivalid      = 1'b0;
        if (rstn) begin
            unique case (state_q)
                S_REQ:  ifu_arvalid = 1'b1;
                S_WAIT: ifu_rready  = 1'b1;
                S_DROP: ifu_rready  = 1'b1;
                S_HOLD: Ivalid      = ~redirect_valid;
                default: ;
            endcase
        end
    end

    // A redirect always wins the PC; otherwise the PC only moves on a decode hand-off.
    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        err_d  = err_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (state_q == S_HOLD && Dready) begin
            pc_d = pc_q + DATA_WIDTH'(4);
        end
        if (state_q == S_WAIT && ifu_rvalid && !redirect_valid) begin
            inst_d = ifu_rdata;
            err_d  = (ifu_rresp != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q   <= RESET_PC;
            inst_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
            err_q  <= err_d;
        end
    end

    assign ifu_araddr = pc_q;
    assign InstF      = inst_q;
    assign PCF        = pc_q;
    assign PCPlus4F   = pc_q + DATA_WIDTH'(4);
    assign fetch_err  = err_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    // A masked HOLD cycle under redirect is neither a hand-off nor a stall.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (Ivalid && Dready) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (state_q == S_HOLD && !Dready && !redirect_valid) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
